guess_game_ctrl: RTL and testbench

Game sequencer for a 3-digit bulls-and-cows ("xAyB") game, driven by the PS/2 digit-entry block.
- Takes the decoded digits and their ready level from the keyboard front end.
- The first accepted entry is the secret; later entries are guesses.
- Each guess is compared position-by-position over multiple cycles; the block reports A/B counts and tracks tries.
- Drives win/lose/error status to the display and LED logic.

---
 rtl/guess_game_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_guess_game_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/guess_game_ctrl.sv
// Bulls-and-cows (xAyB) game sequencer: secret entry, multi-cycle guess scoring,
// try counting and win/lose/error status for the display and LED logic.
module guess_game_ctrl #(
  parameter int unsigned MAX_TRIES = 8
) (
  input  logic       CLK,
  input  logic       reset_n,
  input  logic [3:0] iNum1,
  input  logic [3:0] iNum2,
  input  logic [3:0] iNum3,
  input  logic       iNumRdy,
  input  logic       iRestart,
  output logic [1:0] oA,
  output logic [1:0] oB,
  output logic       oResultVld,
  output logic [3:0] oTries,
  output logic       oWin,
  output logic       oLose,
  output logic       oErr,
  output logic [2:0] oState,
  output logic [2:0] oLED
);

  localparam int unsigned DW = 4;  // digit width
  localparam int unsigned CW = 2;  // A/B count width
  localparam int unsigned TW = 4;  // tries width
  localparam int unsigned IW = 2;  // check index width
  localparam int unsigned SW = 3;  // state width

  typedef enum logic [SW-1:0] {
    S_IDLE   = 3'd0,
    S_GUESS  = 3'd1,
    S_CHECK  = 3'd2,
    S_REPORT = 3'd3,
    S_WIN    = 3'd4,
    S_LOSE   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic          rdy_q, rdy_d;
  logic [DW-1:0] sec0_q, sec1_q, sec2_q;
  logic [DW-1:0] sec0_d, sec1_d, sec2_d;
  logic [DW-1:0] gs0_q, gs1_q, gs2_q;
  logic [DW-1:0] gs0_d, gs1_d, gs2_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] acc_a_q, acc_a_d;
  logic [CW-1:0] acc_b_q, acc_b_d;
  logic [CW-1:0] a_q, a_d;
  logic [CW-1:0] b_q, b_d;
  logic          vld_q, vld_d;
  logic [TW-1:0] tries_q, tries_d;
  logic          win_q, win_d;
  logic          lose_q, lose_d;
  logic          err_q, err_d;
  logic [2:0]    led_q, led_d;

  logic          edge_c;
  logic          entry_ok_c;
  logic [DW-1:0] g_c;
  logic [DW-1:0] s_c;
  logic          hit_any_c;
  logic [TW-1:0] tries_inc_c;

  // Entry edge detect, validity check and per-position compare operands
  always_comb begin
    edge_c     = iNumRdy & ~rdy_q;
    entry_ok_c = (iNum1 <= DW'(9)) && (iNum2 <= DW'(9)) && (iNum3 <= DW'(9)) &&
                 (iNum1 != iNum2) && (iNum1 != iNum3) && (iNum2 != iNum3);
    case (idx_q)
      2'd1:    begin g_c = gs1_q; s_c = sec1_q; end
      2'd2:    begin g_c = gs2_q; s_c = sec2_q; end
      default: begin g_c = gs0_q; s_c = sec0_q; end
    endcase
    // Secret digits are distinct, so a non-positional hit means another position
    hit_any_c   = (g_c == sec0_q) || (g_c == sec1_q) || (g_c == sec2_q);
    tries_inc_c = (tries_q == TW'(15)) ? tries_q : tries_q + TW'(1);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    rdy_d   = iNumRdy;
    sec0_d  = sec0_q;
    sec1_d  = sec1_q;
    sec2_d  = sec2_q;
    gs0_d   = gs0_q;
    gs1_d   = gs1_q;
    gs2_d   = gs2_q;
    idx_d   = idx_q;
    acc_a_d = acc_a_q;
    acc_b_d = acc_b_q;
    a_d     = a_q;
    b_d     = b_q;
    vld_d   = 1'b0;
    tries_d = tries_q;
    err_d   = 1'b0;

    if (iRestart) begin
      state_d = S_IDLE;
      idx_d   = '0;
      acc_a_d = '0;
      acc_b_d = '0;
      a_d     = '0;
      b_d     = '0;
      tries_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (edge_c) begin
            if (entry_ok_c) begin
              sec0_d  = iNum1;
              sec1_d  = iNum2;
              sec2_d  = iNum3;
              tries_d = '0;
              state_d = S_GUESS;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_GUESS: begin
          if (edge_c) begin
            if (entry_ok_c) begin
              gs0_d   = iNum1;
              gs1_d   = iNum2;
              gs2_d   = iNum3;
              acc_a_d = '0;
              acc_b_d = '0;
              idx_d   = '0;
              state_d = S_CHECK;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_CHECK: begin
          if (g_c == s_c) begin
            acc_a_d = acc_a_q + CW'(1);
          end else if (hit_any_c) begin
            acc_b_d = acc_b_q + CW'(1);
          end
          if (idx_q == IW'(2)) begin
            idx_d   = '0;
            state_d = S_REPORT;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        S_REPORT: begin
          a_d     = acc_a_q;
          b_d     = acc_b_q;
          vld_d   = 1'b1;
          tries_d = tries_inc_c;
          if (acc_a_q == CW'(3)) begin
            state_d = S_WIN;
          end else if (tries_inc_c == TW'(MAX_TRIES)) begin
            state_d = S_LOSE;
          end else begin
            state_d = S_GUESS;
          end
        end
        S_WIN, S_LOSE: begin
          state_d = state_q;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    win_d  = (state_d == S_WIN);
    lose_d = (state_d == S_LOSE);
    led_d  = {lose_d, win_d, state_d == S_GUESS};
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      rdy_q   <= 1'b0;
      sec0_q  <= '0;
      sec1_q  <= '0;
      sec2_q  <= '0;
      gs0_q   <= '0;
      gs1_q   <= '0;
      gs2_q   <= '0;
      idx_q   <= '0;
      acc_a_q <= '0;
      acc_b_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      vld_q   <= 1'b0;
      tries_q <= '0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
      err_q   <= 1'b0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      sec0_q  <= sec0_d;
      sec1_q  <= sec1_d;
      sec2_q  <= sec2_d;
      gs0_q   <= gs0_d;
      gs1_q   <= gs1_d;
      gs2_q   <= gs2_d;
      idx_q   <= idx_d;
      acc_a_q <= acc_a_d;
      acc_b_q <= acc_b_d;
      a_q     <= a_d;
      b_q     <= b_d;
      vld_q   <= vld_d;
      tries_q <= tries_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
      err_q   <= err_d;
      led_q   <= led_d;
    end
  end

  assign oA         = a_q;
  assign oB         = b_q;
  assign oResultVld = vld_q;
  assign oTries     = tries_q;
  assign oWin       = win_q;
  assign oLose      = lose_q;
  assign oErr       = err_q;
  assign oState     = state_q;
  assign oLED       = led_q;

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Scoreboard bench for guess_game_ctrl: directed entries push expected A/B/tries,
// a negedge monitor pops and compares on every result pulse.
module tb_guess_game_ctrl;

  logic       CLK = 1'b0;
  logic       reset_n;
  logic [3:0] iNum1, iNum2, iNum3;
  logic       iNumRdy, iRestart;
  logic [1:0] oA, oB;
  logic       oResultVld;
  logic [3:0] oTries;
  logic       oWin, oLose, oErr;
  logic [2:0] oState;
  logic [2:0] oLED;

  guess_game_ctrl #(.MAX_TRIES(8)) dut (
    .CLK(CLK), .reset_n(reset_n),
    .iNum1(iNum1), .iNum2(iNum2), .iNum3(iNum3),
    .iNumRdy(iNumRdy), .iRestart(iRestart),
    .oA(oA), .oB(oB), .oResultVld(oResultVld), .oTries(oTries),
    .oWin(oWin), .oLose(oLose), .oErr(oErr), .oState(oState), .oLED(oLED)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
    logic [3:0] tries;
  } res_t;

  res_t exp_q[$];
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   n_vld  = 0;
  int   n_push = 0;
  int   n_err  = 0;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic push(input int a, input int b, input int t);
    res_t r;
    r.a = 2'(a); r.b = 2'(b); r.tries = 4'(t);
    exp_q.push_back(r);
    n_push++;
  endtask

  // Present an entry with iNumRdy high for 'hold' cycles
  task automatic entry(input int d1, input int d2, input int d3, input int hold);
    iNum1 = 4'(d1); iNum2 = 4'(d2); iNum3 = 4'(d3);
    iNumRdy = 1'b1;
    tick(hold);
    iNumRdy = 1'b0;
  endtask

  task automatic restart();
    iRestart = 1'b1;
    tick(1);
    iRestart = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, int'(oState), 0);
    chk({tag, "_ab"}, int'({oA, oB}), 0);
    chk({tag, "_tries"}, int'(oTries), 0);
    chk({tag, "_flags"}, int'({oWin, oLose, oErr, oResultVld}), 0);
    chk({tag, "_led"}, int'(oLED), 0);
  endtask

  // Monitor: pop and compare on each result pulse, count error pulses
  always @(negedge CLK) begin
    if (reset_n === 1'b1) begin
      if (oResultVld === 1'b1) begin
        n_vld++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: got A=%0d B=%0d tries=%0d, expected no pulse", oA, oB, oTries);
        end else begin
          res_t r;
          r = exp_q.pop_front();
          chk("result_a_b_tries", int'({oA, oB, oTries}), int'(r));
        end
      end
      if (oErr === 1'b1) n_err++;
      if (oErr === 1'b1 || oResultVld === 1'b1)
        chk("err_vld_exclusive", int'(oErr & oResultVld), 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; iRestart = 1'b0; iNumRdy = 1'b0;
    iNum1 = '0; iNum2 = '0; iNum3 = '0;
    tick(3);
    chk_all_zero("reset");
    reset_n = 1'b1;
    tick(1);

    // 1: secret 123, guess 321 -> 1A2B
    entry(1, 2, 3, 1);
    tick(1);
    chk("t1_guess_state", int'(oState), 1);
    chk("t1_led", int'(oLED), 3'b001);
    push(1, 2, 1);
    entry(3, 2, 1, 1);
    tick(5);
    chk("t1_state", int'(oState), 1);
    chk("t1_tries", int'(oTries), 1);

    // 2: winning guess, later entry ignored
    push(3, 0, 2);
    entry(1, 2, 3, 1);
    tick(5);
    chk("t2_state", int'(oState), 4);
    chk("t2_win", int'(oWin), 1);
    chk("t2_led", int'(oLED), 3'b010);
    entry(4, 5, 6, 1);
    tick(6);
    chk("t2_tries_hold", int'(oTries), 2);
    chk("t2_state_hold", int'(oState), 4);

    // 3: invalid secrets rejected, then a valid one
    restart();
    chk("t3_restart_state", int'(oState), 0);
    chk("t3_restart_tries", int'(oTries), 0);
    chk("t3_restart_win", int'(oWin), 0);
    entry(1, 1, 2, 1);
    tick(2);
    entry(7, 10, 3, 1);
    tick(2);
    chk("t3_err_count", n_err, 2);
    chk("t3_idle", int'(oState), 0);
    entry(9, 8, 7, 1);
    tick(1);
    chk("t3_guess", int'(oState), 1);
    chk("t3_tries", int'(oTries), 0);

    // 4: eight misses lead to LOSE
    restart();
    entry(1, 2, 3, 1);
    tick(1);
    for (int i = 0; i < 8; i++) begin
      push(0, 0, i + 1);
      entry(4, 5, 6, 1);
      tick(5);
    end
    chk("t4_tries", int'(oTries), 8);
    chk("t4_lose", int'(oLose), 1);
    chk("t4_led", int'(oLED), 3'b100);
    chk("t4_state", int'(oState), 5);

    // 5: long iNumRdy level gives one result; guess 132 vs 123 -> 1A2B
    restart();
    entry(1, 2, 3, 1);
    tick(1);
    push(1, 2, 1);
    entry(1, 3, 2, 100);
    tick(5);
    chk("t5_tries", int'(oTries), 1);
    chk("t5_state", int'(oState), 1);
    chk("t5_vld_count", n_vld, n_push);

    // 6: restart in 2nd CHECK cycle with a simultaneous edge, then reset mid-check
    restart();
    entry(1, 2, 3, 1);
    tick(1);
    entry(3, 2, 1, 1);
    tick(1);
    iNum1 = 4'd7; iNum2 = 4'd8; iNum3 = 4'd9;
    iNumRdy = 1'b1; iRestart = 1'b1;
    tick(1);
    iNumRdy = 1'b0; iRestart = 1'b0;
    chk("t6_state", int'(oState), 0);
    chk("t6_ab", int'({oA, oB}), 0);
    chk("t6_tries", int'(oTries), 0);
    tick(6);
    chk("t6_still_idle", int'(oState), 0);
    entry(1, 2, 3, 1);
    tick(1);
    entry(3, 2, 1, 1);
    tick(1);
    reset_n = 1'b0;
    tick(1);
    chk_all_zero("t6_reset");
    reset_n = 1'b1;
    tick(8);
    chk("final_vld_count", n_vld, n_push);
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_err_count", n_err, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
